bin_to_bcd_seq: RTL and testbench

Sequential double-dabble converter that turns an N-bit unsigned binary value into D packed BCD digits. It sits directly downstream of the Fibonacci generator: its `bin` input is driven from the generator's `fib` result, and it is started from the generator's `done` pulse. Its `bcd` output feeds the seven-segment display driver. It uses the same `start`/`ready`/`done` handshake as the rest of the arithmetic chain and takes one iteration per input bit.

---
 rtl/bin_to_bcd_seq.sv | 128 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble converter, N-bit unsigned binary
// to D packed BCD digits, one iteration per input bit, using the
// start/ready/done handshake of the arithmetic chain.
// Optional feature macro: BIN_TO_BCD_OVF_EN (registered overflow flag; when
// undefined, ovf is tied to 0).
module bin_to_bcd_seq #(
  parameter int N = 20,
  parameter int D = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   bin,
  output logic           ready,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           ovf
);

  localparam int CW = $clog2(N + 1);
`ifdef BIN_TO_BCD_OVF_EN
  localparam int AW = 4 * D + 1;
`else
  localparam int AW = 4 * D;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    OP   = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   bin_q, bin_d;
  logic [4*D-1:0] bcd_q, bcd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4*D-1:0] adj;
  logic [AW-1:0]  shifted;
  logic [3:0]     dig;

  // Per-digit +3 correction for every digit >= 5, no carry between digits
  always_comb begin
    adj = bcd_q;
    dig = '0;
    for (int unsigned i = 0; i < D; i++) begin
      dig = bcd_q[4*i +: 4];
      if (dig >= 4'd5) dig = dig + 4'd3;
      adj[4*i +: 4] = dig;
    end
  end

  // Corrected digits shifted left with the binary MSB entering at bit 0.
  // The bit leaving the top digit is kept only when the overflow flag exists.
  always_comb begin
    shifted = AW'({adj, bin_q[N-1]});
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = CW'(N);
          state_d = OP;
        end
      end
      OP: begin
        bcd_d = shifted[4*D-1:0];
        bin_d = bin_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BIN_TO_BCD_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: cleared on accepted start, accumulates top-digit carry-outs
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && start) ovf_d = 1'b0;
    else if (state_q == OP)       ovf_d = ovf_q | shifted[AW-1];
  end

  // Overflow register
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign bcd   = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq: a D=7 instance for the
// main function and handshake, and a D=5 instance for the modulo/overflow case.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [19:0] bin, bin2;
  logic        ready, done, ovf;
  logic        ready2, done2, ovf2;
  logic [27:0] bcd;
  logic [19:0] bcd2;

  int checks = 0;
  int errors = 0;

`ifdef BIN_TO_BCD_OVF_EN
  localparam logic OVF_BIG = 1'b1;
`else
  localparam logic OVF_BIG = 1'b0;
`endif

  bin_to_bcd_seq #(.N(20), .D(7)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready), .done(done), .bcd(bcd), .ovf(ovf)
  );

  bin_to_bcd_seq #(.N(20), .D(5)) dut5 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .ready(ready2), .done(done2), .bcd(bcd2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One conversion on the D=7 instance; done must appear 20 edges after the accept edge
  task automatic convert(input string tag, input logic [19:0] v, input logic [27:0] exp_bcd,
                         input logic exp_ovf);
    int n;
    n = 0;
    start = 1'b1; bin = v;
    tick();
    start = 1'b0; bin = 20'hABCDE;
    check({tag, "_ready_op"}, {31'd0, ready}, 32'd0);
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 32'd20);
    check({tag, "_bcd"}, {4'd0, bcd}, {4'd0, exp_bcd});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    tick();
    check({tag, "_idle"}, {30'd0, ready, done}, 32'd2);
  endtask

  // One conversion on the D=5 instance
  task automatic convert5(input string tag, input logic [19:0] v, input logic [19:0] exp_bcd,
                          input logic exp_ovf);
    int n;
    n = 0;
    start2 = 1'b1; bin2 = v;
    tick();
    start2 = 1'b0; bin2 = 20'h55555;
    while (!done2 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 32'd20);
    check({tag, "_bcd"}, {12'd0, bcd2}, {12'd0, exp_bcd});
    check({tag, "_ovf"}, {31'd0, ovf2}, {31'd0, exp_ovf});
    tick();
  endtask

  initial begin
    int n;
    int first_t, second_t, ndone;

    rst = 1'b1; start = 1'b0; bin = '0; start2 = 1'b0; bin2 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {4'd0, bcd}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    tick();

    convert("zero", 20'd0, 28'h0000000, 1'b0);
    convert("fib30", 20'd832040, 28'h0832040, 1'b0);
    convert("max", 20'd1048575, 28'h1048575, 1'b0);
    convert("fib20", 20'd6765, 28'h0006765, 1'b0);

    // Result holds in IDLE until the next accepted start
    tick(); tick();
    check("hold_bcd", {4'd0, bcd}, 32'h0006765);

    // Second start during OP is ignored: exactly one done, result of the first operand
    start = 1'b1; bin = 20'd5;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; bin = 20'd9;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) ndone++;
      tick();
    end
    check("ign_ndone", ndone, 32'd1);
    check("ign_bcd", {4'd0, bcd}, 32'h0000005);

    // Start held high: back-to-back conversions every N+2 cycles
    first_t = -1; second_t = -1;
    start = 1'b1; bin = 20'd12345;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (done) begin
        if (first_t < 0) begin
          first_t = t;
          check("b2b_bcd", {4'd0, bcd}, 32'h0012345);
        end else if (second_t < 0) begin
          second_t = t;
        end
      end
    end
    start = 1'b0;
    check("b2b_period", second_t - first_t, 32'd22);
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    check("b2b_drain", {31'd0, ready}, 32'd1);
    tick();

    // Reset at OP iteration 10 aborts the conversion
    start = 1'b1; bin = 20'd999999;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_bcd", {4'd0, bcd}, 32'd0);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_nodone", ndone, 32'd0);
    convert("after_abort", 20'd999999, 28'h0999999, 1'b0);

    // Narrow instance: results modulo 10^5, overflow only in the macro build
    convert5("d5_123456", 20'd123456, 20'h23456, OVF_BIG);
    convert5("d5_99999", 20'd99999, 20'h99999, 1'b0);
    convert5("d5_max", 20'd1048575, 20'h48575, OVF_BIG);
    convert5("d5_100000", 20'd100000, 20'h00000, OVF_BIG);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
